// File: rtl/ds1302_pkg.sv
// ds1302_pkg: shared definitions for the DS1302 three-wire interface.
//   - state_t        : controller FSM state encoding
//   - HALF_DIV_DEFAULT: clk cycles per SCLK half-period (1 MHz SCLK at 50 MHz)
//   - T_CE_DEFAULT   : clk cycles for CE setup / hold / inactive gap (4 us)
//   - BITS_*         : bit totals of each serial phase
package ds1302_pkg;

  localparam int HALF_DIV_DEFAULT = 25;
  localparam int T_CE_DEFAULT     = 200;

  typedef enum logic [2:0] {
    IDLE,
    CE_SETUP,
    TX,
    RX,
    CE_HOLD,
    GAP,
    DONE
  } state_t;

  localparam logic [6:0] BITS_WR_A    = 7'd16;
  localparam logic [6:0] BITS_WR_B    = 7'd72;
  localparam logic [6:0] BITS_RD_CMD  = 7'd8;
  localparam logic [6:0] BITS_RD_DATA = 7'd64;

endpackage

// File: rtl/ds1302_sclk_gen.sv
// ds1302_sclk_gen: SCLK generator with half-period timing.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   en         : run SCLK; when low SCLK is held low and the divider is cleared
//   sclk       : serial clock; each bit is a low half then a high half
//   rise, fall : one-clk strobes on the clk edge where sclk goes high / low
module ds1302_sclk_gen
  import ds1302_pkg::*;
#(
  parameter int HALF_DIV = HALF_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam logic [15:0] DIV_LAST = 16'(HALF_DIV - 1);

  logic [15:0] div_cnt_reg;
  logic        half_tick;

  // Last clk of the current half-period: sclk toggles on this edge.
  assign half_tick = en && (div_cnt_reg == DIV_LAST);
  assign rise      = half_tick && !sclk;
  assign fall      = half_tick && sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      sclk        <= 1'b0;
    end else if (!en) begin
      div_cnt_reg <= '0;
      sclk        <= 1'b0;
    end else if (half_tick) begin
      div_cnt_reg <= '0;
      sclk        <= ~sclk;
    end else begin
      div_cnt_reg <= div_cnt_reg + 16'd1;
    end
  end

endmodule

// File: rtl/ds1302_if.sv
// ds1302_if: DS1302 RTC three-wire controller.
// A write sends bytes 0-1 in one CE session, then bytes 2-10 in a second
// session after a CE-low gap. A read sends byte 0 then clocks in 64 bits.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   wr_vld      : start strobe, accepted only in IDLE
//   din[87:0]   : command/data bytes, byte k = din[8k+7:8k], LSB first on wire
//   wr          : 0 = write, 1 = read
//   opera_done  : one-cycle completion pulse
//   rd_data     : burst-read result (byte 0 in [7:0]); held between reads
//   busy        : high from accept through the opera_done cycle
//   ds_ce, ds_sclk, ds_io : DS1302 pins (ds_io tri-stated when not driving)
module ds1302_if
  import ds1302_pkg::*;
#(
  parameter int HALF_DIV = HALF_DIV_DEFAULT,
  parameter int T_CE     = T_CE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_vld,
  input  logic [87:0] din,
  input  logic        wr,
  output logic        opera_done,
  output logic [63:0] rd_data,
  output logic        busy,
  output logic        ds_ce,
  output logic        ds_sclk,
  inout  wire         ds_io
);

  localparam logic [15:0] T_CE_LAST = 16'(T_CE - 1);

  state_t      state_reg;
  logic [87:0] tx_sh_reg;
  logic [63:0] rx_sh_reg;
  logic        wr_reg;        // latched operation type (1 = read)
  logic        second_reg;    // write session B in progress
  logic [15:0] timer_reg;
  logic [6:0]  bit_cnt_reg;   // rising edges sent in the current phase
  logic [6:0]  bit_total_reg;
  logic        sclk_en_reg;
  logic        io_oe_reg;
  logic        io_out_reg;
  logic        sclk_rise;
  logic        sclk_fall;

  assign ds_io = io_oe_reg ? io_out_reg : 1'bz;

  ds1302_sclk_gen #(.HALF_DIV(HALF_DIV)) u_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (sclk_en_reg),
    .sclk (ds_sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      tx_sh_reg     <= '0;
      rx_sh_reg     <= '0;
      wr_reg        <= 1'b0;
      second_reg    <= 1'b0;
      timer_reg     <= '0;
      bit_cnt_reg   <= '0;
      bit_total_reg <= '0;
      sclk_en_reg   <= 1'b0;
      io_oe_reg     <= 1'b0;
      io_out_reg    <= 1'b0;
      opera_done    <= 1'b0;
      rd_data       <= '0;
      busy          <= 1'b0;
      ds_ce         <= 1'b0;
    end else begin
      if (sclk_rise) begin
        bit_cnt_reg <= bit_cnt_reg + 7'd1;
      end
      case (state_reg)
        IDLE: begin
          if (wr_vld) begin
            tx_sh_reg     <= din;
            wr_reg        <= wr;
            second_reg    <= 1'b0;
            bit_total_reg <= wr ? BITS_RD_CMD : BITS_WR_A;
            busy          <= 1'b1;
            ds_ce         <= 1'b1;
            timer_reg     <= '0;
            state_reg     <= CE_SETUP;
          end
        end
        CE_SETUP: begin
          if (timer_reg == T_CE_LAST) begin
            timer_reg   <= '0;
            bit_cnt_reg <= '0;
            sclk_en_reg <= 1'b1;
            io_oe_reg   <= 1'b1;
            io_out_reg  <= tx_sh_reg[0];
            state_reg   <= TX;
          end else begin
            timer_reg <= timer_reg + 16'd1;
          end
        end
        TX: begin
          // Next bit goes out at the start of its low half (the falling edge).
          if (sclk_fall) begin
            tx_sh_reg  <= tx_sh_reg >> 1;
            io_out_reg <= tx_sh_reg[1];
            if (bit_cnt_reg == bit_total_reg) begin
              bit_cnt_reg <= '0;
              io_oe_reg   <= 1'b0;
              if (wr_reg) begin
                // SCLK keeps running straight into the read data phase.
                bit_total_reg <= BITS_RD_DATA;
                state_reg     <= RX;
              end else begin
                sclk_en_reg <= 1'b0;
                state_reg   <= CE_HOLD;
              end
            end
          end
        end
        RX: begin
          // Sample on the last clk of the high half, LSB first.
          if (sclk_fall) begin
            rx_sh_reg <= {ds_io, rx_sh_reg[63:1]};
            if (bit_cnt_reg == bit_total_reg) begin
              bit_cnt_reg <= '0;
              sclk_en_reg <= 1'b0;
              state_reg   <= CE_HOLD;
            end
          end
        end
        CE_HOLD: begin
          if (timer_reg == T_CE_LAST) begin
            timer_reg <= '0;
            ds_ce     <= 1'b0;
            if (!wr_reg && !second_reg) begin
              second_reg    <= 1'b1;
              bit_total_reg <= BITS_WR_B;
              state_reg     <= GAP;
            end else begin
              opera_done <= 1'b1;
              if (wr_reg) begin
                rd_data <= rx_sh_reg;
              end
              state_reg <= DONE;
            end
          end else begin
            timer_reg <= timer_reg + 16'd1;
          end
        end
        GAP: begin
          if (timer_reg == T_CE_LAST) begin
            timer_reg <= '0;
            ds_ce     <= 1'b1;
            state_reg <= CE_SETUP;
          end else begin
            timer_reg <= timer_reg + 16'd1;
          end
        end
        DONE: begin
          opera_done <= 1'b0;
          busy       <= 1'b0;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ds1302_if.md
DS1302_IF -- requirements
Module: ds1302_if

Interface
REQ-001 SHALL have port clk, input, 1, system clock (50 MHz).
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port wr_vld, input, 1, one-cycle operation start strobe.
REQ-004 SHALL have port din, input, 88, command/data bytes, byte k = din[8k+7:8k], sent LSB first.
REQ-005 SHALL have port wr, input, 1, operation type: 0 = write, 1 = read.
REQ-006 SHALL have port opera_done, output, 1, one-cycle pulse when an operation is complete.
REQ-007 SHALL have port rd_data, output, 64, burst-read result, byte 0 (seconds) in rd_data[7:0].
REQ-008 SHALL have port busy, output, 1, high from accept to opera_done inclusive.
REQ-009 SHALL have port ds_ce, output, 1, DS1302 CE pin.
REQ-010 SHALL have port ds_sclk, output, 1, DS1302 SCLK pin.
REQ-011 SHALL have port ds_io, inout, 1, DS1302 I/O pin, driven only when the internal output enable is high, otherwise high-Z.
REQ-012 SHALL have parameter HALF_DIV, default 25, clk cycles per SCLK half-period (1 MHz SCLK).
REQ-013 SHALL have parameter T_CE, default 200, clk cycles for CE setup, CE hold and CE-inactive gap (4 us).

Function
REQ-014 SHALL accept wr_vld only in IDLE, latch din and wr on that edge, and ignore wr_vld while busy.
REQ-015 SHALL run write as two CE sessions: session A sends bytes 0-1 (16 bits), then a T_CE CE-low gap, then session B sends bytes 2-10 (72 bits).
REQ-016 SHALL run read as one CE session: send byte 0 (8 bits), then receive 64 bits; bytes 1-10 are ignored.
REQ-017 SHALL use these states: IDLE, CE_SETUP, TX, RX, CE_HOLD, GAP, DONE.
REQ-018 SHALL sequence states as IDLE -> CE_SETUP (CE high, T_CE cycles) -> TX -> [RX if read] -> CE_HOLD (T_CE cycles, SCLK low) -> CE low -> GAP (write session A only) -> CE_SETUP again, else DONE -> IDLE.
REQ-019 SHALL hold SCLK low idle; each bit is one low half followed by one high half of HALF_DIV cycles each.
REQ-020 SHALL set the TX bit on ds_io at the start of the low half, so it is stable on the SCLK rising edge.
REQ-021 SHALL release ds_io in RX starting from the falling edge after the 8th command rising edge.
REQ-022 SHALL sample ds_io in RX on the last clk of each high half and shift it in LSB first into rd_data[0..63] in order.
REQ-023 SHALL count bits with a 7-bit counter and end TX/RX exactly at the programmed bit total (16, 72, 8 or 64), with no extra SCLK edge.
REQ-024 SHALL pulse opera_done for one cycle in DONE and update rd_data only on read completion; rd_data is held otherwise.
REQ-025 SHALL make the new operation take effect if wr_vld coincides with the DONE cycle is not the case: that wr_vld SHALL be ignored; it is accepted only from IDLE.

Reset
REQ-026 SHALL asynchronously force, on rst_n low (including mid-operation), state IDLE, ds_ce=0, ds_sclk=0, ds_io high-Z, opera_done=0, busy=0, rd_data=0 and all counters 0.
REQ-027 SHALL produce no opera_done for an operation aborted by reset.

Structure
REQ-028 SHALL place state encodings and default HALF_DIV/T_CE in a shared package ds1302_pkg.
REQ-029 SHALL implement SCLK and half-period timing in one sub-module ds1302_sclk_gen (enable, half_tick, rise/fall strobes); everything else stays in ds1302_if.

Verification
REQ-030 SHALL verify that after reset, with no wr_vld, ds_ce=0, ds_sclk=0, ds_io=Z and busy=0 for 10 us.
REQ-031 SHALL verify write: wr=0, din=88'h0023011015130101BE008E -> session A bits 8E,00; a CE gap of at least 4 us; session B bits BE,01,01,13,15,10,01,23,00 LSB first; 88 SCLK rising edges in total; one opera_done.
REQ-032 SHALL verify read: wr=1, din=88'h00BF with a model returning 00,30,12,15,10,01,23,00 -> command BF observed, 72 SCLK rising edges, rd_data=64'h0023011015123000 with opera_done.
REQ-033 SHALL verify a wr_vld pulsed mid-write is ignored: exactly one operation runs and one opera_done is produced.
REQ-034 SHALL verify that rst_n asserted during RX bit 30 drops CE, SCLK and io-enable immediately and produces no opera_done; a following read completes correctly.
REQ-035 SHALL verify timing: CE rise to first SCLK rise is at least T_CE + HALF_DIV cycles, and the last SCLK fall to CE fall is at least T_CE cycles.
